// File: rtl/keccak_round_sequencer.sv
// Round/step sequencer for the permutation datapath: issues one-hot start pulses
// to the step units, waits for each done level and strobes the state write-back.
module keccak_round_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int NUM_STEPS  = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NUM_STEPS-1:0] i_step_done,
    output logic [NUM_STEPS-1:0] o_step_start,
    output logic [2:0]           o_sel,
    output logic                 o_load_en,
    output logic                 o_state_we,
    output logic [4:0]           o_round_idx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS - 1);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

    state_t               r_state;
    logic [2:0]           r_step;
    logic [4:0]           r_round;
    logic [7:0]           r_tmo;
    logic [NUM_STEPS-1:0] r_step_start;
    logic                 r_load_en;
    logic                 r_state_we;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_cur_done;
    logic [7:0]           w_tmo_next;

    function automatic logic [NUM_STEPS-1:0] f_onehot(input logic [2:0] idx);
        logic [NUM_STEPS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (idx == 3'(i)) v[i] = 1'b1;
            else              v[i] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic f_bit_at(input logic [NUM_STEPS-1:0] vec, input logic [2:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (idx == 3'(i)) b = vec[i];
            else              b = b;
        end
        return b;
    endfunction

    // Only the done level of the step currently in flight matters.
    always_comb begin
        w_cur_done = f_bit_at(i_step_done, r_step);
        w_tmo_next = (r_tmo == TMO_LIM) ? r_tmo : (r_tmo + 8'd1);
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_step       <= 3'd0;
            r_round      <= 5'd0;
            r_tmo        <= 8'd0;
            r_step_start <= '0;
            r_load_en    <= 1'b0;
            r_state_we   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_step_start <= '0;
            r_load_en    <= 1'b0;
            r_state_we   <= 1'b0;
            r_done       <= 1'b0;
            if (i_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_error <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ERR: begin
                        if (i_start) begin
                            r_state   <= S_LOAD;
                            r_load_en <= 1'b1;
                            r_busy    <= 1'b1;
                            r_error   <= 1'b0;
                            r_round   <= 5'd0;
                            r_step    <= 3'd0;
                        end
                    end
                    S_LOAD: begin
                        r_state      <= S_ISSUE;
                        r_step_start <= f_onehot(r_step);
                    end
                    S_ISSUE: begin
                        r_state <= S_WAIT;
                        r_tmo   <= 8'd0;
                    end
                    S_WAIT: begin
                        if (w_cur_done) begin
                            r_state    <= S_WB;
                            r_state_we <= 1'b1;
                        end else begin
                            r_tmo <= w_tmo_next;
                            if (w_tmo_next == TMO_LIM) begin
                                r_state <= S_ERR;
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_WB: begin
                        if (r_step != LAST_STEP) begin
                            r_step       <= r_step + 3'd1;
                            r_state      <= S_ISSUE;
                            r_step_start <= f_onehot(r_step + 3'd1);
                        end else if (r_round != LAST_ROUND) begin
                            r_step       <= 3'd0;
                            r_round      <= r_round + 5'd1;
                            r_state      <= S_ISSUE;
                            r_step_start <= f_onehot(3'd0);
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_error <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_step_start = r_step_start;
    assign o_sel        = r_step;
    assign o_load_en    = r_load_en;
    assign o_state_we   = r_state_we;
    assign o_round_idx  = r_round;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule
